lc3_mem_mp: RTL and testbench

Parametrised multi-port word memory for the PUnC LC-3 datapath. It is the next generation of the existing 2-read/1-write memory and adds:
- a configurable number of read ports;
- a selectable combinational or registered read with write-first bypass;
- a hardware clear sequencer that runs after reset;
- a valid/ready program-loader port;
- out-of-range address protection.

It sits between the PUnC controller/datapath and the testbench program loader.

---
 rtl/lc3_mem_pkg.sv | 26 ++
 rtl/lc3_mem_mp_if.sv | 42 ++++
 rtl/lc3_mem_rd_port.sv | 69 ++++++
 rtl/lc3_mem_mp.sv | 151 +++++++++++++++
 tb/tb_lc3_mem_mp.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_pkg
// Description : Shared types, constants and helpers for the LC-3 multi-port
//               word memory. Provides the sequencer state enum, the LC-3
//               word width, the default depth and the address range check.
// Revision    : 1.0  initial release
// ============================================================================
package lc3_mem_pkg;

    localparam int c_word_width    = 16;
    localparam int c_default_depth = 128;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_t;

    // Addresses are widened to 32 bits by the caller, so ADDR_WIDTH <= 32.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_mp_if
// Description : Bus bundle for lc3_mem_mp.
//               master : datapath / program loader side
//               slave  : memory side
//               r_addr/r_data : packed read ports, port k at [k*W +: W]
//               w_addr/w_data/w_en : datapath write port
//               ld_valid/ld_ready/ld_addr/ld_data : loader write handshake
//               mem_ready : memory running, oob_err : sticky range error
// Revision    : 1.0  initial release
// ============================================================================
interface lc3_mem_mp_if
    import lc3_mem_pkg::*;
#(
    parameter int N_RD_PORTS = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = c_word_width
);
    logic [N_RD_PORTS*ADDR_WIDTH-1:0] r_addr;
    logic [N_RD_PORTS*DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0]            w_addr;
    logic [DATA_WIDTH-1:0]            w_data;
    logic                             w_en;
    logic                             ld_valid;
    logic                             ld_ready;
    logic [ADDR_WIDTH-1:0]            ld_addr;
    logic [DATA_WIDTH-1:0]            ld_data;
    logic                             mem_ready;
    logic                             oob_err;

    modport master (
        output r_addr, w_addr, w_data, w_en, ld_valid, ld_addr, ld_data,
        input  r_data, ld_ready, mem_ready, oob_err
    );

    modport slave (
        input  r_addr, w_addr, w_data, w_en, ld_valid, ld_addr, ld_data,
        output r_data, ld_ready, mem_ready, oob_err
    );
endinterface
`default_nettype wire

// File: rtl/lc3_mem_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_rd_port
// Description : One read port of lc3_mem_mp. Applies the range check and the
//               run gate to the array word, then either passes it straight
//               out (READ_LATENCY=0) or registers it with optional
//               write-first forwarding (READ_LATENCY=1).
//   clk, rst       : clock, asynchronous active-low reset
//   i_run          : memory is in RUN state
//   i_addr         : read address
//   i_mem_word     : array word at the truncated read address
//   i_wr_commit    : a write commits this cycle
//   i_wr_addr/data : committed write address/data
//   o_rd_data      : read data
// Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_rd_port
    import lc3_mem_pkg::*;
#(
    parameter int N_ELEMENTS   = c_default_depth,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = c_word_width,
    parameter int READ_LATENCY = 0,
    parameter int WRITE_FIRST  = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_run,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_mem_word,
    input  wire logic                  i_wr_commit,
    input  wire logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wr_data,
    output logic      [DATA_WIDTH-1:0] o_rd_data
);
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_in_range = addr_in_range(32'(i_addr), 32'(N_ELEMENTS));
    // Out-of-range reads and every read outside RUN return zero; the array
    // word for an out-of-range address is an alias and must not leak out.
    assign w_word = (i_run && w_in_range) ? i_mem_word : '0;

    if (READ_LATENCY == 0) begin : g_comb
        logic w_unused;
        assign w_unused  = &{1'b0, clk, rst, i_wr_commit, i_wr_addr, i_wr_data};
        assign o_rd_data = w_word;
    end else begin : g_reg
        logic                  w_bypass;
        logic [DATA_WIDTH-1:0] r_rd_data;

        // A matching in-range read address implies the write is in range too.
        assign w_bypass = (WRITE_FIRST != 0) && i_run && w_in_range &&
                          i_wr_commit && (i_wr_addr == i_addr);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rd_data <= '0;
            end else if (w_bypass) begin
                r_rd_data <= i_wr_data;
            end else begin
                r_rd_data <= w_word;
            end
        end

        assign o_rd_data = r_rd_data;
    end
endmodule
`default_nettype wire

// File: rtl/lc3_mem_mp.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_mp
// Description : Parametrised multi-port word memory for the PUnC LC-3
//               datapath. Hardware clear after reset, N read ports with
//               optional registered read and write-first bypass, a
//               valid/ready loader port arbitrated below the datapath
//               write, and sticky out-of-range write detection.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : lc3_mem_mp_if slave (read ports, write port, loader, status)
// Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_mp
    import lc3_mem_pkg::*;
#(
    parameter int N_ELEMENTS     = c_default_depth,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = c_word_width,
    parameter int N_RD_PORTS     = 2,
    parameter int READ_LATENCY   = 0,
    parameter int WRITE_FIRST    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    lc3_mem_mp_if.slave bus
);
    localparam int               c_idx_w    = $clog2(N_ELEMENTS);
    localparam logic [c_idx_w-1:0] c_last_ptr = c_idx_w'(N_ELEMENTS - 1);
    localparam mem_state_t       c_rst_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    mem_state_t            r_state;
    mem_state_t            w_state_next;
    logic [c_idx_w-1:0]    r_clear_ptr;
    logic                  r_oob_err;
    logic [DATA_WIDTH-1:0] r_mem [N_ELEMENTS];

    logic                  w_run;
    logic                  w_ld_ready;
    logic                  w_wr_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_wr_in_range;
    logic [DATA_WIDTH-1:0] w_rd_data [N_RD_PORTS];

    assign w_run = (r_state == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the single-write arbitration: datapath before loader.
    always_comb begin
        w_state_next = r_state;
        w_ld_ready   = 1'b0;
        w_wr_commit  = 1'b0;
        w_wr_addr    = '0;
        w_wr_data    = '0;
        case (r_state)
            ST_CLEAR: begin
                if (r_clear_ptr == c_last_ptr) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ld_ready = !bus.w_en;
                if (bus.w_en) begin
                    w_wr_commit = 1'b1;
                    w_wr_addr   = bus.w_addr;
                    w_wr_data   = bus.w_data;
                end else if (bus.ld_valid) begin
                    w_wr_commit = 1'b1;
                    w_wr_addr   = bus.ld_addr;
                    w_wr_data   = bus.ld_data;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    assign w_wr_in_range = addr_in_range(32'(w_wr_addr), 32'(N_ELEMENTS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clear_ptr <= '0;
            r_oob_err   <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clear_ptr <= r_clear_ptr + c_idx_w'(1);
            end
            if (w_wr_commit && !w_wr_in_range) begin
                r_oob_err <= 1'b1;
            end
        end
    end

    // Array is not reset; the rst gate keeps a held reset from writing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clear_ptr] <= '0;
            end else if (w_wr_commit && w_wr_in_range) begin
                r_mem[w_wr_addr[c_idx_w-1:0]] <= w_wr_data;
            end
        end
    end

    for (genvar k = 0; k < N_RD_PORTS; k++) begin : g_rd_port
        logic [ADDR_WIDTH-1:0] w_port_addr;
        logic [DATA_WIDTH-1:0] w_port_word;

        assign w_port_addr = bus.r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_port_word = r_mem[w_port_addr[c_idx_w-1:0]];

        lc3_mem_rd_port #(
            .N_ELEMENTS   (N_ELEMENTS),
            .ADDR_WIDTH   (ADDR_WIDTH),
            .DATA_WIDTH   (DATA_WIDTH),
            .READ_LATENCY (READ_LATENCY),
            .WRITE_FIRST  (WRITE_FIRST)
        ) u_rd_port (
            .clk         (clk),
            .rst         (rst),
            .i_run       (w_run),
            .i_addr      (w_port_addr),
            .i_mem_word  (w_port_word),
            .i_wr_commit (w_wr_commit),
            .i_wr_addr   (w_wr_addr),
            .i_wr_data   (w_wr_data),
            .o_rd_data   (w_rd_data[k])
        );
    end

    always_comb begin
        bus.r_data = '0;
        for (int k = 0; k < N_RD_PORTS; k++) begin
            bus.r_data[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[k];
        end
    end

    assign bus.ld_ready  = w_ld_ready;
    assign bus.mem_ready = w_run;
    assign bus.oob_err   = r_oob_err;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_mem_mp
// Description : Testbench for lc3_mem_mp. Three instances share one stimulus:
//               a = combinational read, b = registered write-first,
//               c = registered read-old. A behavioural memory model is
//               checked against all of them every cycle, alongside
//               directed scenarios with literal expected values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lc3_mem_mp;
    localparam int N  = 128;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NP*AW-1:0] r_addr   = '0;
    logic [AW-1:0]    w_addr   = '0;
    logic [DW-1:0]    w_data   = '0;
    logic             w_en     = 1'b0;
    logic             ld_valid = 1'b0;
    logic [AW-1:0]    ld_addr  = '0;
    logic [DW-1:0]    ld_data  = '0;

    lc3_mem_mp_if #(.N_RD_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    lc3_mem_mp_if #(.N_RD_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();
    lc3_mem_mp_if #(.N_RD_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

    assign ifa.r_addr = r_addr;   assign ifb.r_addr = r_addr;   assign ifc.r_addr = r_addr;
    assign ifa.w_addr = w_addr;   assign ifb.w_addr = w_addr;   assign ifc.w_addr = w_addr;
    assign ifa.w_data = w_data;   assign ifb.w_data = w_data;   assign ifc.w_data = w_data;
    assign ifa.w_en   = w_en;     assign ifb.w_en   = w_en;     assign ifc.w_en   = w_en;
    assign ifa.ld_valid = ld_valid; assign ifb.ld_valid = ld_valid; assign ifc.ld_valid = ld_valid;
    assign ifa.ld_addr  = ld_addr;  assign ifb.ld_addr  = ld_addr;  assign ifc.ld_addr  = ld_addr;
    assign ifa.ld_data  = ld_data;  assign ifb.ld_data  = ld_data;  assign ifc.ld_data  = ld_data;

    lc3_mem_mp #(.N_ELEMENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_RD_PORTS(NP),
                 .READ_LATENCY(0), .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    lc3_mem_mp #(.N_ELEMENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_RD_PORTS(NP),
                 .READ_LATENCY(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    lc3_mem_mp #(.N_ELEMENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_RD_PORTS(NP),
                 .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
        u_c (.clk(clk), .rst(rst), .bus(ifc));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // After reset the clear makes every word zero before anything can read
    // it, so the model simply holds an all-zero image from reset onward.
    logic [15:0] m_mem [N];
    bit          m_run;
    int          m_clr;
    bit          m_oob;
    logic [15:0] m_rb [NP];
    logic [15:0] m_rc [NP];

    function automatic void model_reset();
        m_run = 1'b0; m_clr = 0; m_oob = 1'b0;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        for (int k = 0; k < NP; k++) begin m_rb[k] = '0; m_rc[k] = '0; end
    endfunction

    function automatic logic [15:0] model_read(input int a);
        return (m_run && a < N) ? m_mem[a] : 16'h0000;
    endfunction

    always @(negedge clk) begin
        int a;
        bit commit;
        int wa;
        logic [15:0] wd;
        if (!rst) model_reset();
        chk("rdy_a", 16'(ifa.mem_ready), 16'(m_run));
        chk("rdy_b", 16'(ifb.mem_ready), 16'(m_run));
        chk("rdy_c", 16'(ifc.mem_ready), 16'(m_run));
        chk("ldrdy_a", 16'(ifa.ld_ready), 16'(m_run && !w_en));
        chk("ldrdy_b", 16'(ifb.ld_ready), 16'(m_run && !w_en));
        chk("oob_a", 16'(ifa.oob_err), 16'(m_oob));
        chk("oob_c", 16'(ifc.oob_err), 16'(m_oob));
        for (int k = 0; k < NP; k++) begin
            a = int'(r_addr[k*AW +: AW]);
            chk($sformatf("a_rd%0d", k), ifa.r_data[k*DW +: DW], model_read(a));
            chk($sformatf("b_rd%0d", k), ifb.r_data[k*DW +: DW], m_rb[k]);
            chk($sformatf("c_rd%0d", k), ifc.r_data[k*DW +: DW], m_rc[k]);
        end
        // advance the model across the coming rising edge
        if (rst) begin
            if (!m_run) begin
                m_clr++;
                if (m_clr == N) m_run = 1'b1;
            end else begin
                commit = w_en || ld_valid;
                wa = w_en ? int'(w_addr) : int'(ld_addr);
                wd = w_en ? w_data : ld_data;
                for (int k = 0; k < NP; k++) begin
                    a = int'(r_addr[k*AW +: AW]);
                    m_rc[k] = model_read(a);
                    m_rb[k] = (commit && wa == a && a < N) ? wd : model_read(a);
                end
                if (commit) begin
                    if (wa < N) m_mem[wa] = wd;
                    else        m_oob = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 16'($urandom_range(128, 65535));
        if (r < 6)  return 16'($urandom_range(0, 31));
        return 16'($urandom_range(0, 127));
    endfunction

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (ifa.mem_ready) break;
        end
        chk(name, 16'(n), 16'd128);
    endtask

    initial begin
        int hold;
        repeat (3) step();
        #1;
        chk("rst_ready", 16'(ifa.mem_ready), 16'd0);
        chk("rst_oob", 16'(ifa.oob_err), 16'd0);
        chk("rst_b_rd", ifb.r_data[15:0], 16'h0000);

        rst = 1'b1;
        count_clear("clear_cycles");
        r_addr = {16'd127, 16'd0};
        #1;
        chk("clr_a_rd0", ifa.r_data[15:0], 16'h0000);
        chk("clr_a_rd127", ifa.r_data[31:16], 16'h0000);

        // datapath write, combinational visibility after the edge
        step();
        w_en = 1'b1; w_addr = 16'd5; w_data = 16'h2017; r_addr = {16'd6, 16'd5};
        step();
        w_en = 1'b0;
        #1;
        chk("wr5_a_p0", ifa.r_data[15:0], 16'h2017);
        chk("wr5_a_p1", ifa.r_data[31:16], 16'h0000);
        chk("wr5_b_p0", ifb.r_data[15:0], 16'h2017);
        chk("wr5_c_p0", ifc.r_data[15:0], 16'h0000);
        step();
        chk("wr5_c_p0_late", ifc.r_data[15:0], 16'h2017);

        // write-first vs read-old on port 1
        w_en = 1'b1; w_addr = 16'd22; w_data = 16'hF000; r_addr = {16'd22, 16'd0};
        step();
        w_en = 1'b0;
        #1;
        chk("wf_b_p1", ifb.r_data[31:16], 16'hF000);
        chk("wf_c_p1", ifc.r_data[31:16], 16'h0000);

        // datapath beats loader
        w_en = 1'b1; w_addr = 16'd3; w_data = 16'h1802;
        ld_valid = 1'b1; ld_addr = 16'd4; ld_data = 16'h040D;
        #1;
        chk("arb_ldrdy0", 16'(ifa.ld_ready), 16'd0);
        step();
        w_en = 1'b0;
        r_addr = {16'd4, 16'd3};
        #1;
        chk("arb_ldrdy1", 16'(ifa.ld_ready), 16'd1);
        chk("arb_addr4_old", ifa.r_data[31:16], 16'h0000);
        step();
        ld_valid = 1'b0;
        #1;
        chk("arb_addr3", ifa.r_data[15:0], 16'h1802);
        chk("arb_addr4", ifa.r_data[31:16], 16'h040D);

        // out-of-range write
        w_en = 1'b1; w_addr = 16'd200; w_data = 16'hBEEF; r_addr = {16'd72, 16'd200};
        step();
        w_en = 1'b0;
        #1;
        chk("oob_set", 16'(ifa.oob_err), 16'd1);
        chk("oob_rd200", ifa.r_data[15:0], 16'h0000);
        chk("oob_alias72", ifa.r_data[31:16], 16'h0000);
        repeat (3) step();
        chk("oob_sticky", 16'(ifa.oob_err), 16'd1);
        chk("oob_b_rd200", ifb.r_data[15:0], 16'h0000);

        // reset in RUN clears everything at once
        r_addr = {16'd3, 16'd5};
        step();
        chk("pre_rst_b", ifb.r_data[15:0], 16'h2017);
        rst = 1'b0;
        #1;
        chk("run_rst_oob", 16'(ifa.oob_err), 16'd0);
        chk("run_rst_ready", 16'(ifa.mem_ready), 16'd0);
        chk("run_rst_b", ifb.r_data[15:0], 16'h0000);
        chk("run_rst_a", ifa.r_data[15:0], 16'h0000);
        step();
        rst = 1'b1;

        // reset mid-clear at clear_ptr = 60
        repeat (60) step();
        rst = 1'b0;
        #1;
        chk("midclr_ready", 16'(ifa.mem_ready), 16'd0);
        step();
        rst = 1'b1;
        count_clear("reclear_cycles");
        #1;
        chk("reclear_addr5", ifa.r_data[15:0], 16'h0000);

        // randomized traffic with occasional resets
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (hold > 0) begin
                hold--;
                if (hold == 0) rst = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                hold = int'($urandom_range(1, 3));
            end
            w_en     = ($urandom_range(0, 2) == 0);
            w_addr   = rand_addr();
            w_data   = 16'($urandom);
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = rand_addr();
            ld_data  = 16'($urandom);
            for (int k = 0; k < NP; k++) begin
                r_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ?
                                     (w_en ? w_addr : ld_addr) : rand_addr();
            end
        end
        rst = 1'b1;
        w_en = 1'b0; ld_valid = 1'b0;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
